// File: rtl/intr_sequencer_pkg.sv
// Shared definitions for the interrupt entry / rfi sequencer: exception codes,
// SPR numbers and one-hot state encodings.
package intr_sequencer_pkg;

  localparam int unsigned EXC_CODE_W = 4;
  localparam int unsigned SPR_AW     = 10;
  localparam int unsigned XLEN       = 32;

  // Exception codes as presented by the interrupt encoder; 0 means nothing pending
  localparam int unsigned EXC_NONE  = 0;
  localparam int unsigned EXC_CRIT  = 1;
  localparam int unsigned EXC_MCHK  = 2;
  localparam int unsigned EXC_DSI   = 3;
  localparam int unsigned EXC_ISI   = 4;
  localparam int unsigned EXC_EXT   = 5;
  localparam int unsigned EXC_ALIGN = 6;
  localparam int unsigned EXC_PROG  = 7;
  localparam int unsigned EXC_SC    = 8;
  localparam int unsigned EXC_DEV0  = 9;
  localparam int unsigned EXC_DEV1  = 10;
  localparam int unsigned EXC_DEC   = 11;
  localparam int unsigned EXC_FIT   = 12;
  localparam int unsigned EXC_WDOG  = 13;
  localparam int unsigned EXC_DMISS = 14;

  localparam logic [SPR_AW-1:0] SPRN_SRR0 = 10'd26;
  localparam logic [SPR_AW-1:0] SPRN_SRR1 = 10'd27;
  localparam logic [SPR_AW-1:0] SPRN_DEAR = 10'd61;

  localparam logic [XLEN-1:0] MSR_CLR_MASK_DFLT = 32'h0006_CB30;

  typedef enum logic [7:0] {
    ISEQ_IDLE  = 8'b0000_0001,
    ISEQ_SAV0  = 8'b0000_0010,
    ISEQ_SAV1  = 8'b0000_0100,
    ISEQ_SAVD  = 8'b0000_1000,
    ISEQ_ENTRY = 8'b0001_0000,
    ISEQ_WCLR  = 8'b0010_0000,
    ISEQ_RFI0  = 8'b0100_0000,
    ISEQ_RFI1  = 8'b1000_0000
  } iseq_state_e;

endpackage

// File: rtl/intr_sequencer.sv
// Interrupt entry sequencer: saves SRR0/SRR1/DEAR, masks MSR, redirects fetch and acks;
// also sequences rfi (restore MSR from SRR1, jump to SRR0).
module intr_sequencer
  import intr_sequencer_pkg::*;
#(
  parameter int unsigned     EXC_W        = EXC_CODE_W,
  parameter logic [XLEN-1:0] MSR_CLR_MASK = MSR_CLR_MASK_DFLT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [EXC_W-1:0]  excepCode,
  input  logic [XLEN-1:0]   intrEntryAddr,
  input  logic [0:31]       pc_excep,
  input  logic [0:31]       pc_next,
  input  logic [0:31]       dear_in,
  input  logic [0:31]       msr_in,
  input  logic              rfi_req,
  input  logic [0:31]       spr_rd,
  output logic [SPR_AW-1:0] spr_addr,
  output logic [0:31]       spr_wd,
  output logic              spr_wr,
  output logic [0:31]       msr_wd,
  output logic              msr_wr,
  output logic              pc_redirect,
  output logic [0:31]       pc_target,
  output logic              flush,
  output logic              busy,
  output logic              ack,
  output logic              rfi_done
);

  iseq_state_e state_q, state_d;

  logic [EXC_W-1:0] code_q;
  logic [0:31]      pc_q, msr_q, dear_q, ret_pc_q;

  logic exc_pending, ret_next, save_dear;

  assign exc_pending = (excepCode != EXC_W'(EXC_NONE));
  // System call and device interrupts resume after the interrupted instruction
  assign ret_next    = (excepCode == EXC_W'(EXC_SC)) || (excepCode == EXC_W'(EXC_DEV0)) ||
                       (excepCode == EXC_W'(EXC_DEV1));
  assign save_dear   = (code_q == EXC_W'(EXC_DSI)) || (code_q == EXC_W'(EXC_DMISS));

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= ISEQ_IDLE;
    else      state_q <= state_d;
  end

  // Context captured at detection; later code changes are ignored
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      code_q   <= '0;
      pc_q     <= '0;
      msr_q    <= '0;
      dear_q   <= '0;
      ret_pc_q <= '0;
    end else begin
      if (state_q == ISEQ_IDLE && exc_pending) begin
        code_q <= excepCode;
        pc_q   <= ret_next ? pc_next : pc_excep;
        msr_q  <= msr_in;
        dear_q <= dear_in;
      end
      if (state_q == ISEQ_RFI0) ret_pc_q <= spr_rd;
    end
  end

  // Next-state logic; an exception wins over a simultaneous rfi
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ISEQ_IDLE: begin
        if (exc_pending)  state_d = ISEQ_SAV0;
        else if (rfi_req) state_d = ISEQ_RFI0;
      end
      ISEQ_SAV0:  state_d = ISEQ_SAV1;
      ISEQ_SAV1:  state_d = save_dear ? ISEQ_SAVD : ISEQ_ENTRY;
      ISEQ_SAVD:  state_d = ISEQ_ENTRY;
      ISEQ_ENTRY: state_d = ISEQ_WCLR;
      ISEQ_WCLR:  state_d = ISEQ_IDLE;
      ISEQ_RFI0:  state_d = ISEQ_RFI1;
      ISEQ_RFI1:  state_d = ISEQ_WCLR;
      default:    state_d = ISEQ_IDLE;
    endcase
  end

  // Output decode
  always_comb begin
    spr_addr    = '0;
    spr_wd      = '0;
    spr_wr      = 1'b0;
    msr_wd      = '0;
    msr_wr      = 1'b0;
    pc_redirect = 1'b0;
    pc_target   = '0;
    flush       = 1'b0;
    ack         = 1'b0;
    rfi_done    = 1'b0;
    busy        = (state_q != ISEQ_IDLE);
    unique case (state_q)
      ISEQ_IDLE: flush = rst && (exc_pending || rfi_req);
      ISEQ_SAV0: begin
        spr_wr   = 1'b1;
        spr_addr = SPRN_SRR0;
        spr_wd   = pc_q;
      end
      ISEQ_SAV1: begin
        spr_wr   = 1'b1;
        spr_addr = SPRN_SRR1;
        spr_wd   = msr_q;
      end
      ISEQ_SAVD: begin
        spr_wr   = 1'b1;
        spr_addr = SPRN_DEAR;
        spr_wd   = dear_q;
      end
      ISEQ_ENTRY: begin
        msr_wr      = 1'b1;
        msr_wd      = msr_q & ~MSR_CLR_MASK;
        pc_redirect = 1'b1;
        pc_target   = intrEntryAddr;
        ack         = 1'b1;
      end
      ISEQ_RFI0: spr_addr = SPRN_SRR0;
      ISEQ_RFI1: begin
        spr_addr    = SPRN_SRR1;
        msr_wr      = 1'b1;
        msr_wd      = spr_rd;
        pc_redirect = 1'b1;
        pc_target   = ret_pc_q;
        rfi_done    = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_intr_sequencer.sv
// Scoreboard bench for intr_sequencer: stimulus queues expected output events with their
// cycle numbers; a negedge monitor pops and compares every event the DUT presents.
module tb_intr_sequencer;
  import intr_sequencer_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [3:0]  excepCode;
  logic [31:0] intrEntryAddr;
  logic [0:31] pc_excep, pc_next, dear_in, msr_in, spr_rd, spr_wd, msr_wd, pc_target;
  logic        rfi_req;
  logic [9:0]  spr_addr;
  logic        spr_wr, msr_wr, pc_redirect, flush, busy, ack, rfi_done;

  always #5 clk = ~clk;

  intr_sequencer dut (
    .clk(clk), .rst(rst), .excepCode(excepCode), .intrEntryAddr(intrEntryAddr),
    .pc_excep(pc_excep), .pc_next(pc_next), .dear_in(dear_in), .msr_in(msr_in),
    .rfi_req(rfi_req), .spr_rd(spr_rd), .spr_addr(spr_addr), .spr_wd(spr_wd),
    .spr_wr(spr_wr), .msr_wd(msr_wd), .msr_wr(msr_wr), .pc_redirect(pc_redirect),
    .pc_target(pc_target), .flush(flush), .busy(busy), .ack(ack), .rfi_done(rfi_done)
  );

  // SPR file model: combinational read, write on clock edge
  logic [31:0] spr_mem [1024];
  always @(posedge clk) if (spr_wr) spr_mem[spr_addr] <= spr_wd;
  assign spr_rd = spr_mem[spr_addr];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  localparam int K_FLUSH = 0, K_SPR = 1, K_ACK = 2, K_RFI = 3;

  typedef struct {
    int          kind;
    logic [9:0]  addr;
    logic [31:0] data;
    logic [31:0] tgt;
    logic [3:0]  flags;  // {msr_wr, pc_redirect, ack, rfi_done}
    int          cyc;
  } ev_t;

  ev_t exp_q[$];
  int  quiet_q[$];
  int  tests = 0, fails = 0;
  logic end_req = 1'b0, done = 1'b0;

  function automatic void push(int kind, logic [9:0] a, logic [31:0] d, logic [31:0] t, int c);
    ev_t e;
    e.kind  = kind;
    e.addr  = a;
    e.data  = d;
    e.tgt   = t;
    e.flags = (kind == K_ACK) ? 4'b1110 : (kind == K_RFI) ? 4'b1101 : 4'b0000;
    e.cyc   = c;
    exp_q.push_back(e);
  endfunction

  // Full exception entry sequence starting at detection cycle det
  function automatic void push_exc(int det, logic [31:0] srr0, logic [31:0] srr1, logic has_dear,
                                   logic [31:0] dear, logic [31:0] msr_exp, logic [31:0] entry);
    push(K_FLUSH, 10'd0, 32'd0, 32'd0, det);
    push(K_SPR, 10'd26, srr0, 32'd0, det + 1);
    push(K_SPR, 10'd27, srr1, 32'd0, det + 2);
    if (has_dear) push(K_SPR, 10'd61, dear, 32'd0, det + 3);
    push(K_ACK, 10'd0, msr_exp, entry, has_dear ? det + 4 : det + 3);
  endfunction

  task automatic check_ev(int kind, logic [9:0] a, logic [31:0] d, logic [31:0] t, logic [3:0] f);
    ev_t e;
    tests++;
    if (exp_q.size() == 0) begin
      fails++;
      $display("FAIL unexpected_event: got kind=%0d addr=%h data=%h tgt=%h flags=%b cyc=%0d, required none",
               kind, a, d, t, f, cyc);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != kind || e.addr != a || e.data != d || e.tgt != t || e.flags != f || e.cyc != cyc) begin
        fails++;
        $display("FAIL event: got kind=%0d addr=%h data=%h tgt=%h flags=%b cyc=%0d, required kind=%0d addr=%h data=%h tgt=%h flags=%b cyc=%0d",
                 kind, a, d, t, f, cyc, e.kind, e.addr, e.data, e.tgt, e.flags, e.cyc);
      end
    end
  endtask

  // Monitor: every output event is matched against the scoreboard
  always @(negedge clk) begin
    if (quiet_q.size() != 0 && quiet_q[0] == cyc) begin
      void'(quiet_q.pop_front());
      tests++;
      if ({spr_wr, msr_wr, pc_redirect, flush, busy, ack, rfi_done} != 7'd0 ||
          spr_addr != 10'd0 || spr_wd != 32'd0 || msr_wd != 32'd0 || pc_target != 32'd0) begin
        fails++;
        $display("FAIL quiet_outputs cyc=%0d: got ctl=%b spr_addr=%h spr_wd=%h msr_wd=%h pc_target=%h, required all 0",
                 cyc, {spr_wr, msr_wr, pc_redirect, flush, busy, ack, rfi_done}, spr_addr, spr_wd, msr_wd, pc_target);
      end
    end
    if (flush) check_ev(K_FLUSH, 10'd0, 32'd0, 32'd0, 4'b0000);
    if (spr_wr) check_ev(K_SPR, spr_addr, spr_wd, 32'd0, 4'b0000);
    if (msr_wr || pc_redirect || ack || rfi_done)
      check_ev(ack ? K_ACK : K_RFI, 10'd0, msr_wd, pc_target, {msr_wr, pc_redirect, ack, rfi_done});
    if (end_req && !done) begin
      tests++;
      if (exp_q.size() != 0 || quiet_q.size() != 0) begin
        fails++;
        $display("FAIL drain: got %0d events %0d quiet checks pending, required 0 0",
                 exp_q.size(), quiet_q.size());
      end
      done <= 1'b1;
    end
  end

  task automatic wait_idle();
    for (int i = 0; i < 40; i++) begin
      if (!busy) return;
      @(posedge clk); #1;
    end
    $display("FAIL wait_idle: busy got 1, required 0 within 40 cycles");
    $fatal(1);
  endtask

  // Returns at #1 into the cycle after ack (WCLR)
  task automatic wait_ack(output int c);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (ack) begin
        c = cyc;
        @(posedge clk); #1;
        return;
      end
    end
    $display("FAIL wait_ack: ack got 0, required 1 within 40 cycles");
    $fatal(1);
  endtask

  task automatic wait_rfi_done();
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (rfi_done) begin
        @(posedge clk); #1;
        return;
      end
    end
    $display("FAIL wait_rfi_done: rfi_done got 0, required 1 within 40 cycles");
    $fatal(1);
  endtask

  task automatic drive_exc(int code, logic [31:0] pe, logic [31:0] pn, logic [31:0] dr,
                           logic [31:0] msr, logic [31:0] entry);
    excepCode     = 4'(code);
    pc_excep      = pe;
    pc_next       = pn;
    dear_in       = dr;
    msr_in        = msr;
    intrEntryAddr = entry;
  endtask

  initial begin
    int det, a;
    excepCode = 4'd0; intrEntryAddr = '0; pc_excep = '0; pc_next = '0;
    dear_in = '0; msr_in = '0; rfi_req = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    #1 quiet_q.push_back(cyc);
    @(posedge clk); #1;
    rst = 1'b1;
    quiet_q.push_back(cyc);
    @(posedge clk); #1;

    // SC: SRR0 from pc_next, EE cleared, no DEAR
    wait_idle();
    drive_exc(EXC_SC, 32'h0000_00FC, 32'h0000_0100, 32'h0, 32'h0000_8000, 32'h0000_0C00);
    det = cyc;
    push_exc(det, 32'h0000_0100, 32'h0000_8000, 1'b0, 32'h0, 32'h0000_0000, 32'h0000_0C00);
    wait_ack(a);
    excepCode = 4'd0;

    // DSI: SRR0 from pc_excep, DEAR saved, ack one cycle later
    wait_idle();
    drive_exc(EXC_DSI, 32'h0000_0200, 32'h0000_0204, 32'hDEAD_0000, 32'h0002_9000, 32'h0000_0600);
    det = cyc;
    push_exc(det, 32'h0000_0200, 32'h0002_9000, 1'b1, 32'hDEAD_0000, 32'h0000_1000, 32'h0000_0600);
    wait_ack(a);
    excepCode = 4'd0;

    // DEV1 leaves SRR0=0x300, SRR1=0x8000 for the rfi that follows
    wait_idle();
    drive_exc(EXC_DEV1, 32'h0000_02FC, 32'h0000_0300, 32'h0, 32'h0000_8000, 32'h0000_0A00);
    det = cyc;
    push_exc(det, 32'h0000_0300, 32'h0000_8000, 1'b0, 32'h0, 32'h0000_0000, 32'h0000_0A00);
    wait_ack(a);
    excepCode = 4'd0;

    wait_idle();
    rfi_req = 1'b1;
    det = cyc;
    push(K_FLUSH, 10'd0, 32'd0, 32'd0, det);
    push(K_RFI, 10'd0, 32'h0000_8000, 32'h0000_0300, det + 2);
    wait_rfi_done();
    rfi_req = 1'b0;

    // DSI and rfi in the same cycle: exception first, rfi after WCLR returns to it
    wait_idle();
    drive_exc(EXC_DSI, 32'h0000_0400, 32'h0000_0404, 32'h0000_4444, 32'h0000_9000, 32'h0000_0600);
    rfi_req = 1'b1;
    det = cyc;
    push_exc(det, 32'h0000_0400, 32'h0000_9000, 1'b1, 32'h0000_4444, 32'h0000_1000, 32'h0000_0600);
    push(K_FLUSH, 10'd0, 32'd0, 32'd0, det + 6);
    push(K_RFI, 10'd0, 32'h0000_9000, 32'h0000_0400, det + 8);
    wait_ack(a);
    excepCode = 4'd0;
    wait_rfi_done();
    rfi_req = 1'b0;

    // Reset during SAV1 aborts; held DSI restarts from scratch after release
    wait_idle();
    drive_exc(EXC_DSI, 32'h0000_0900, 32'h0000_0904, 32'hAAAA_5555, 32'h0000_1000, 32'h0000_0600);
    det = cyc;
    push(K_FLUSH, 10'd0, 32'd0, 32'd0, det);
    push(K_SPR, 10'd26, 32'h0000_0900, 32'd0, det + 1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    quiet_q.push_back(cyc);
    @(posedge clk); #1;
    rst = 1'b1;
    det = cyc;
    push_exc(det, 32'h0000_0900, 32'h0000_1000, 1'b1, 32'hAAAA_5555, 32'h0000_1000, 32'h0000_0600);
    wait_ack(a);
    excepCode = 4'd0;

    // DEV0 switched to DSI during SAV0: latched DEV0 path, entry address sampled late
    wait_idle();
    drive_exc(EXC_DEV0, 32'h0000_04FC, 32'h0000_0500, 32'h1111_0000, 32'h0000_D000, 32'h0000_0900);
    det = cyc;
    push_exc(det, 32'h0000_0500, 32'h0000_D000, 1'b0, 32'h0, 32'h0000_1000, 32'h0000_0600);
    @(posedge clk); #1;
    excepCode = 4'(EXC_DSI);
    intrEntryAddr = 32'h0000_0600;
    wait_ack(a);
    excepCode = 4'd0;

    // Unknown code 15: full save, all-ones vector, no DEAR
    wait_idle();
    drive_exc(15, 32'h0000_0700, 32'h0000_0704, 32'h0000_7777, 32'h0002_0000, 32'hFFFF_FFFF);
    det = cyc;
    push_exc(det, 32'h0000_0700, 32'h0002_0000, 1'b0, 32'h0, 32'h0000_0000, 32'hFFFF_FFFF);
    wait_ack(a);

    // Back-to-back: DMISS presented in WCLR is taken only in the following IDLE cycle
    drive_exc(EXC_DMISS, 32'h0000_0800, 32'h0000_0804, 32'h0000_BEEF, 32'h0000_1200, 32'h0000_0C40);
    push_exc(a + 2, 32'h0000_0800, 32'h0000_1200, 1'b1, 32'h0000_BEEF, 32'h0000_1000, 32'h0000_0C40);
    wait_ack(a);
    excepCode = 4'd0;

    wait_idle();
    repeat (3) @(posedge clk);
    end_req = 1'b1;
    for (int i = 0; i < 10 && !done; i++) @(posedge clk);
    if (!done) begin
      $display("FAIL drain_timeout: monitor done got 0, required 1");
      $fatal(1);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
